// File: rtl/ddr_capture_pkg.sv
// Shared types and sizing for the DDR capture path. These sizes must match the
// 64 x 64-bit capture memory in the register bank.
package ddr_capture_pkg;

    localparam int C_CAP_DEPTH  = 64;
    localparam int C_CAP_ADDR_W = 6;
    localparam int C_CAP_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } t_cap_state;

endpackage

// File: rtl/ddr_capture_writer.sv
// Circular-buffer capture of a DDR sample stream with a programmable pre-trigger
// depth. Writes go to the capture memory through a one-cycle registered port.
module ddr_capture_writer
    import ddr_capture_pkg::*;
#(
    parameter int G_DATA_WIDTH = C_CAP_DATA_W,
    parameter int G_ADDR_WIDTH = C_CAP_ADDR_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    arm_i,
    input  logic                    abort_i,
    input  logic [G_ADDR_WIDTH-1:0] pretrig_i,
    input  logic                    sample_valid_i,
    input  logic [G_DATA_WIDTH-1:0] sample_dat_i,
    input  logic                    trig_i,
    output logic [G_ADDR_WIDTH-1:0] mem_adr_o,
    output logic                    mem_we_o,
    output logic [G_DATA_WIDTH-1:0] mem_dat_o,
    output logic                    armed_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [G_ADDR_WIDTH-1:0] trig_pos_o,
    output logic [G_ADDR_WIDTH-1:0] start_pos_o
);

    localparam int                    DEPTH     = 2 ** G_ADDR_WIDTH;
    localparam logic [G_ADDR_WIDTH:0] FILL_FULL = (G_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [G_ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [G_ADDR_WIDTH-1:0] ADDR_ONE = G_ADDR_WIDTH'(1);

    t_cap_state              state_q, state_d;
    logic [G_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [G_ADDR_WIDTH:0]   fill_q, fill_d;
    logic [G_ADDR_WIDTH-1:0] post_q, post_d;
    logic [G_ADDR_WIDTH-1:0] pretrig_q, pretrig_d;
    logic [G_ADDR_WIDTH-1:0] trig_pos_q, trig_pos_d;
    logic [G_ADDR_WIDTH-1:0] start_pos_q, start_pos_d;
    logic                    mem_we_q, mem_we_d;
    logic [G_ADDR_WIDTH-1:0] mem_adr_q, mem_adr_d;
    logic [G_DATA_WIDTH-1:0] mem_dat_q, mem_dat_d;
    logic                    wr_sample;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        fill_d      = fill_q;
        post_d      = post_q;
        pretrig_d   = pretrig_q;
        trig_pos_d  = trig_pos_q;
        start_pos_d = start_pos_q;
        wr_sample   = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
            ptr_d   = '0;
            fill_d  = '0;
            post_d  = '0;
        end else if (arm_i && state_q != POST) begin
            state_d   = ARMED;
            ptr_d     = '0;
            fill_d    = '0;
            post_d    = '0;
            pretrig_d = pretrig_i;
        end else begin
            case (state_q)
                ARMED: begin
                    if (sample_valid_i) begin
                        wr_sample = 1'b1;
                        ptr_d     = ptr_q + 1'b1;
                        if (fill_q != FILL_FULL) begin
                            fill_d = fill_q + 1'b1;
                        end
                        // fill is compared before this sample is counted
                        if (trig_i && fill_q >= {1'b0, pretrig_q}) begin
                            trig_pos_d  = ptr_q;
                            start_pos_d = ptr_q - pretrig_q;
                            post_d      = ADDR_MAX - pretrig_q;
                            state_d     = (pretrig_q == ADDR_MAX) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (sample_valid_i) begin
                        wr_sample = 1'b1;
                        ptr_d     = ptr_q + 1'b1;
                        post_d    = post_q - 1'b1;
                        if (post_q == ADDR_ONE) begin
                            state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end

        mem_we_d  = wr_sample;
        mem_adr_d = wr_sample ? ptr_q : mem_adr_q;
        mem_dat_d = wr_sample ? sample_dat_i : mem_dat_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            fill_q      <= '0;
            post_q      <= '0;
            pretrig_q   <= '0;
            trig_pos_q  <= '0;
            start_pos_q <= '0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            post_q      <= post_d;
            pretrig_q   <= pretrig_d;
            trig_pos_q  <= trig_pos_d;
            start_pos_q <= start_pos_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_dat_q   <= mem_dat_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_adr_o   = mem_adr_q;
    assign mem_dat_o   = mem_dat_q;
    assign armed_o     = (state_q == ARMED);
    assign busy_o      = (state_q == ARMED) || (state_q == POST);
    assign done_o      = (state_q == DONE);
    assign trig_pos_o  = trig_pos_q;
    assign start_pos_o = start_pos_q;

endmodule

// File: tb/tb_ddr_capture_writer.sv
// Scoreboard bench for ddr_capture_writer: expected memory writes are queued as
// samples are driven and matched against the registered write port.
module tb_ddr_capture_writer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        arm_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [5:0]  pretrig_i = '0;
    logic        sample_valid_i = 1'b0;
    logic [63:0] sample_dat_i = '0;
    logic        trig_i = 1'b0;
    logic [5:0]  mem_adr_o;
    logic        mem_we_o;
    logic [63:0] mem_dat_o;
    logic        armed_o;
    logic        busy_o;
    logic        done_o;
    logic [5:0]  trig_pos_o;
    logic [5:0]  start_pos_o;

    typedef struct {
        logic [5:0]  adr;
        logic [63:0] dat;
        int          cyc;
    } wr_t;

    wr_t        sb[$];
    int         vecCount  = 0;
    int         failCount = 0;
    int         cyc       = 0;
    logic [5:0] expAdr    = '0;

    ddr_capture_writer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .pretrig_i      (pretrig_i),
        .sample_valid_i (sample_valid_i),
        .sample_dat_i   (sample_dat_i),
        .trig_i         (trig_i),
        .mem_adr_o      (mem_adr_o),
        .mem_we_o       (mem_we_o),
        .mem_dat_o      (mem_dat_o),
        .armed_o        (armed_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .trig_pos_o     (trig_pos_o),
        .start_pos_o    (start_pos_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vecCount++;
        if (obs !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, release just after the
    // rising edge so the caller can inspect the registered result.
    task automatic applyStimulus(input logic rst, input logic arm, input logic abort,
                                 input logic [5:0] pre, input logic valid,
                                 input logic trig, input logic expWr);
        logic [63:0] d;
        @(negedge clk_i);
        d              = {$urandom, $urandom};
        rst_i          = rst;
        arm_i          = arm;
        abort_i        = abort;
        pretrig_i      = pre;
        sample_valid_i = valid;
        sample_dat_i   = d;
        trig_i         = trig;
        if (expWr) begin
            sb.push_back('{expAdr, d, cyc + 1});
            expAdr++;
        end
        @(posedge clk_i);
        #1;
        rst_i          = 1'b0;
        arm_i          = 1'b0;
        abort_i        = 1'b0;
        sample_valid_i = 1'b0;
        trig_i         = 1'b0;
    endtask

    task automatic sample(input logic trig, input logic expWr);
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, trig, expWr);
    endtask

    task automatic armCapture(input logic [5:0] pre);
        applyStimulus(1'b0, 1'b1, 1'b0, pre, 1'b1, 1'b0, 1'b0);
        expAdr = '0;
    endtask

    // Every write strobe must match the oldest queued expectation, one cycle
    // after the sample that caused it.
    always @(negedge clk_i) begin
        if (mem_we_o) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_we", {58'd0, mem_adr_o}, 64'hFFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                checkOutput("we_adr", {58'd0, mem_adr_o}, {58'd0, e.adr});
                checkOutput("we_dat", mem_dat_o, e.dat);
                checkOutput("we_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_we", {63'd0, mem_we_o}, 64'd0);
        checkOutput("rst_adr", {58'd0, mem_adr_o}, 64'd0);
        checkOutput("rst_dat", mem_dat_o, 64'd0);
        checkOutput("rst_flags", {61'd0, armed_o, busy_o, done_o}, 64'd0);
        checkOutput("rst_pos", {52'd0, trig_pos_o, start_pos_o}, 64'd0);

        // pretrig 4, trigger on sample 7, fill all 64 slots
        armCapture(6'd4);
        checkOutput("t1_armed", {62'd0, armed_o, busy_o}, 64'd3);
        for (int k = 0; k < 10; k++) sample(k == 7, 1'b1);
        checkOutput("t1_post", {61'd0, armed_o, busy_o, done_o}, 64'd2);
        checkOutput("t1_trig_pos", {58'd0, trig_pos_o}, 64'd7);
        checkOutput("t1_start_pos", {58'd0, start_pos_o}, 64'd3);
        for (int k = 10; k < 66; k++) sample(1'b0, 1'b1);
        checkOutput("t1_not_done", {63'd0, done_o}, 64'd0);
        sample(1'b0, 1'b1);
        checkOutput("t1_done", {61'd0, armed_o, busy_o, done_o}, 64'd1);
        for (int k = 0; k < 3; k++) sample(1'b1, 1'b0);
        checkOutput("t1_done_hold", {63'd0, done_o}, 64'd1);

        // pretrig 10, early triggers ignored, then abort with post = 20
        armCapture(6'd10);
        checkOutput("t2_done_clr", {63'd0, done_o}, 64'd0);
        for (int k = 0; k < 12; k++) sample(k == 2 || k == 5, 1'b1);
        checkOutput("t2_still_armed", {63'd0, armed_o}, 64'd1);
        sample(1'b1, 1'b1);
        checkOutput("t2_trig_pos", {58'd0, trig_pos_o}, 64'd12);
        checkOutput("t2_start_pos", {58'd0, start_pos_o}, 64'd2);
        for (int k = 13; k < 46; k++) sample(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("t2_abort_idle", {61'd0, armed_o, busy_o, done_o}, 64'd0);
        checkOutput("t2_abort_pos", {52'd0, trig_pos_o, start_pos_o}, {52'd0, 6'd12, 6'd2});
        for (int k = 0; k < 3; k++) sample(1'b1, 1'b0);
        checkOutput("t2_idle_trig", {61'd0, armed_o, busy_o, done_o}, 64'd0);

        // pretrig 0: immediate trigger, restart at address 0, arm in POST ignored
        armCapture(6'd0);
        checkOutput("t3_armed", {61'd0, armed_o, busy_o, done_o}, 64'd6);
        sample(1'b1, 1'b1);
        checkOutput("t3_trig_pos", {52'd0, trig_pos_o, start_pos_o}, 64'd0);
        checkOutput("t3_post", {61'd0, armed_o, busy_o, done_o}, 64'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd9, 1'b1, 1'b1, 1'b1);
        checkOutput("t3_arm_in_post", {61'd0, armed_o, busy_o, done_o}, 64'd2);
        checkOutput("t3_pos_kept", {52'd0, trig_pos_o, start_pos_o}, 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        armCapture(6'd5);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_arm_abort", {61'd0, armed_o, busy_o, done_o}, 64'd0);

        // pretrig 63: trigger on the 64th sample goes straight to DONE
        armCapture(6'd63);
        for (int k = 0; k < 63; k++) sample(k == 30 || k == 62, 1'b1);
        checkOutput("t4_armed", {63'd0, armed_o}, 64'd1);
        sample(1'b1, 1'b1);
        checkOutput("t4_done_we", {62'd0, done_o, mem_we_o}, 64'd3);
        checkOutput("t4_trig_pos", {58'd0, trig_pos_o}, 64'd63);
        checkOutput("t4_start_pos", {58'd0, start_pos_o}, 64'd0);
        sample(1'b0, 1'b0);
        checkOutput("t4_done_hold", {63'd0, done_o}, 64'd1);

        // reset in POST clears everything with no partial write
        armCapture(6'd0);
        sample(1'b1, 1'b1);
        sample(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_rst_we", {63'd0, mem_we_o}, 64'd0);
        checkOutput("t5_rst_out", {52'd0, mem_adr_o, trig_pos_o}, 64'd0);
        checkOutput("t5_rst_dat", mem_dat_o, 64'd0);
        checkOutput("t5_rst_flags", {58'd0, start_pos_o} | {61'd0, armed_o, busy_o, done_o}, 64'd0);
        sample(1'b1, 1'b0);
        checkOutput("t5_idle_trig", {61'd0, armed_o, busy_o, done_o}, 64'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
